// File: rtl/mem_wr_rd_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_wr_rd_seq
//
// Purpose:
//   Write/readback sequencer for a single-port synchronous memory. A start pulse
//   latches a base address, a word count and a seed value. The block then writes
//   the words seed, seed+1, ... to consecutive addresses base, base+1, ...
//   (addresses wrap at 2**ADDR_WIDTH). It reads the same addresses back and
//   compares each returned word with the value it wrote. The result is reported
//   as a saturating mismatch count, the address of the first mismatch, and a
//   sticky pass flag.
//
// Ports:
//   clk             in   clock, all state changes on the rising edge
//   reset_n         in   synchronous active-low reset
//   start           in   one-cycle request to begin a pass (ignored while busy)
//   abort           in   stop the current pass and return to idle
//   base_addr       in   [ADDR_WIDTH-1:0]  first address of the pass
//   length          in   [ADDR_WIDTH:0]    number of words, 0..2**ADDR_WIDTH
//   seed            in   [DATA_WIDTH-1:0]  data value of the first word
//   addr0_b0        out  [ADDR_WIDTH-1:0]  memory address
//   ce0_b0          out  memory chip enable
//   we0_b0          out  memory write enable (qualified by ce0_b0)
//   d0_b0           out  [DATA_WIDTH-1:0]  memory write data
//   q0_b0           in   [DATA_WIDTH-1:0]  memory read data, one cycle after a read
//   reg_en          out  high in the cycle q0_b0 carries read data
//   busy            out  a pass is in progress
//   done            out  one-cycle pulse when a pass completes normally
//   err_cnt         out  [ADDR_WIDTH:0]    saturating readback mismatch count
//   first_err_addr  out  [ADDR_WIDTH-1:0]  address of the first mismatch
//   pass            out  set at completion when no mismatch was found; held
//                        until the next start
// -----------------------------------------------------------------------------
module mem_wr_rd_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [ADDR_WIDTH-1:0] addr0_b0,
    output logic                  ce0_b0,
    output logic                  we0_b0,
    output logic [DATA_WIDTH-1:0] d0_b0,
    input  logic [DATA_WIDTH-1:0] q0_b0,
    output logic                  reg_en,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  pass
);

    // MEM_DEPTH describes the attached memory only. Addressing always wraps
    // at 2**ADDR_WIDTH, whatever the physical depth is.
    if (MEM_DEPTH < 1) begin : g_depth_descriptive_only
    end

    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // Control state (reset)
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic                    cmp_vld_q, cmp_vld_d;
    logic [ADDR_WIDTH:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
    logic                    pass_q, pass_d;

    // Pass parameters and compare data (no reset; only used while busy)
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic                    last_word;
    logic                    mismatch;

    // Saturating increment for the mismatch counter.
    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        cmp_vld_d        = 1'b0;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        pass_d           = pass_q;
        base_d           = base_q;
        len_d            = len_q;
        seed_d           = seed_q;
        exp_d            = exp_q;
        cmp_addr_d       = cmp_addr_q;

        addr0_b0         = '0;
        ce0_b0           = 1'b0;
        we0_b0           = 1'b0;
        d0_b0            = '0;
        done             = 1'b0;

        // Address and data wrap naturally at their register widths.
        cur_addr  = base_q + idx_q[ADDR_WIDTH-1:0];
        cur_data  = seed_q + DATA_WIDTH'(idx_q);
        last_word = (idx_q == (len_q - CNT_ONE));

        // The compare runs one cycle behind the read it belongs to, independent
        // of the current state, so the final read is checked in DRAIN.
        mismatch = cmp_vld_q && (q0_b0 != exp_q);
        if (mismatch) begin
            // The counter never wraps back to zero, so zero means "no error yet".
            if (err_cnt_q == CNT_ZERO) begin
                first_err_addr_d = cmp_addr_q;
            end
            err_cnt_d = sat_inc(err_cnt_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d           = base_addr;
                    len_d            = length;
                    seed_d           = seed;
                    idx_d            = '0;
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                    if (length != CNT_ZERO) begin
                        pass_d  = 1'b0;
                        state_d = S_WRITE;
                    end else begin
                        // An empty pass completes with no errors.
                        pass_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_WRITE: begin
                ce0_b0   = 1'b1;
                we0_b0   = 1'b1;
                addr0_b0 = cur_addr;
                d0_b0    = cur_data;
                if (last_word) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else begin
                    idx_d   = idx_q + CNT_ONE;
                end
            end

            S_READ: begin
                ce0_b0     = 1'b1;
                addr0_b0   = cur_addr;
                cmp_vld_d  = 1'b1;
                exp_d      = cur_data;
                cmp_addr_d = cur_addr;
                if (last_word) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d   = idx_q + CNT_ONE;
                end
            end

            S_DRAIN: begin
                // Uses the post-compare count so the final word is included and
                // pass is already valid alongside the done pulse.
                pass_d  = (err_cnt_d == CNT_ZERO);
                state_d = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything else, including start and completion.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cmp_vld_d = 1'b0;
            pass_d    = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            cmp_vld_q        <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cmp_vld_q        <= cmp_vld_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            pass_q           <= pass_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q     <= base_d;
        len_q      <= len_d;
        seed_q     <= seed_d;
        exp_q      <= exp_d;
        cmp_addr_q <= cmp_addr_d;
    end

    assign reg_en         = cmp_vld_q;
    assign busy           = (state_q != S_IDLE);
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_mem_wr_rd_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_wr_rd_seq
//
// Purpose:
//   Directed testbench for mem_wr_rd_seq. It uses a 256-word behavioural memory
//   that can be given a stuck-at-0 bit 0 on its read port. A passive monitor
//   logs every memory access and counts reg_en and done cycles.
// -----------------------------------------------------------------------------
module tb_mem_wr_rd_seq;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] seed;
    logic [AW-1:0] addr0_b0;
    logic          ce0_b0;
    logic          we0_b0;
    logic [DW-1:0] d0_b0;
    logic [DW-1:0] q0_b0;
    logic          reg_en;
    logic          busy;
    logic          done;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_err_addr;
    logic          pass;

    always #5 clk = ~clk;

    mem_wr_rd_seq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (512)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .addr0_b0       (addr0_b0),
        .ce0_b0         (ce0_b0),
        .we0_b0         (we0_b0),
        .d0_b0          (d0_b0),
        .q0_b0          (q0_b0),
        .reg_en         (reg_en),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .pass           (pass)
    );

    // Behavioural single-port memory with one-cycle read latency.
    logic [DW-1:0] mem [0:255];
    logic          stuck0;

    always @(posedge clk) begin
        if (ce0_b0) begin
            if (we0_b0) mem[addr0_b0] <= d0_b0;
            else        q0_b0 <= mem[addr0_b0] & (stuck0 ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        end
    end

    // Access log and event counters, sampled mid-cycle.
    logic          acc_we   [$];
    logic [AW-1:0] acc_addr [$];
    logic [DW-1:0] acc_d    [$];
    int            n_regen = 0;
    int            n_done  = 0;

    always @(negedge clk) begin
        if (ce0_b0) begin
            acc_we.push_back(we0_b0);
            acc_addr.push_back(addr0_b0);
            acc_d.push_back(d0_b0);
        end
        if (reg_en) n_regen++;
        if (done)   n_done++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] s);
        base_addr = b;
        length    = l;
        seed      = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_we"},   64'(acc_we[idx]),   64'(w));
        chk({tag, "_addr"}, 64'(acc_addr[idx]), 64'(a));
        chk({tag, "_data"}, 64'(acc_d[idx]),    64'(d));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  64'(addr0_b0),       64'(0));
        chk({tag, "_ce"},    64'(ce0_b0),         64'(0));
        chk({tag, "_we"},    64'(we0_b0),         64'(0));
        chk({tag, "_d"},     64'(d0_b0),          64'(0));
        chk({tag, "_regen"}, 64'(reg_en),         64'(0));
        chk({tag, "_busy"},  64'(busy),           64'(0));
        chk({tag, "_done"},  64'(done),           64'(0));
        chk({tag, "_errc"},  64'(err_cnt),        64'(0));
        chk({tag, "_ferr"},  64'(first_err_addr), 64'(0));
        chk({tag, "_pass"},  64'(pass),           64'(0));
    endtask

    initial begin
        int            cyc;
        int            m;
        int            r;
        int            d;
        int            dup;
        logic [255:0]  seen;
        logic [AW-1:0] a;
        logic [AW-1:0] wrap_a [4];
        logic [DW-1:0] wrap_d [4];

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        seed      = '0;
        stuck0    = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // Single word: W1 -> R1 -> DRAIN -> DONE
        m = acc_we.size(); r = n_regen; d = n_done;
        start_pass(8'h01, 9'd1, 32'h1);
        wait_done(cyc);
        chk("t1_cycles", 64'(cyc), 64'(3));
        chk("t1_pass", 64'(pass), 64'(1));
        chk("t1_errc", 64'(err_cnt), 64'(0));
        chk("t1_busy_done", 64'(busy), 64'(1));
        chk("t1_nacc", 64'(acc_we.size() - m), 64'(2));
        chk_acc("t1_w0", m,     1'b1, 8'h01, 32'h1);
        chk_acc("t1_r0", m + 1, 1'b0, 8'h01, 32'h0);
        tick();
        chk("t1_done_pulse", 64'(done), 64'(0));
        chk("t1_idle_busy", 64'(busy), 64'(0));
        chk("t1_pass_held", 64'(pass), 64'(1));
        chk("t1_regen_cnt", 64'(n_regen - r), 64'(1));
        chk("t1_done_cnt", 64'(n_done - d), 64'(1));

        // Address and data wrap
        wrap_a[0] = 8'hFE; wrap_a[1] = 8'hFF; wrap_a[2] = 8'h00; wrap_a[3] = 8'h01;
        wrap_d[0] = 32'hFFFF_FFFF; wrap_d[1] = 32'h0; wrap_d[2] = 32'h1; wrap_d[3] = 32'h2;
        m = acc_we.size();
        start_pass(8'hFE, 9'd4, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("t2_cycles", 64'(cyc), 64'(9));
        chk("t2_pass", 64'(pass), 64'(1));
        chk("t2_nacc", 64'(acc_we.size() - m), 64'(8));
        for (int i = 0; i < 4; i++) begin
            chk_acc($sformatf("t2_w%0d", i), m + i,     1'b1, wrap_a[i], wrap_d[i]);
            chk_acc($sformatf("t2_r%0d", i), m + 4 + i, 1'b0, wrap_a[i], 32'h0);
        end
        tick();

        // Stuck-at-0 bit 0: reads 0,0,2,2 against 0,1,2,3
        stuck0 = 1'b1;
        start_pass(8'h10, 9'd4, 32'h0);
        wait_done(cyc);
        chk("t3_errc", 64'(err_cnt), 64'(2));
        chk("t3_ferr", 64'(first_err_addr), 64'(8'h11));
        chk("t3_pass", 64'(pass), 64'(0));
        stuck0 = 1'b0;
        tick();
        chk("t3_errc_held", 64'(err_cnt), 64'(2));

        // Zero length: start cycle, then DONE
        m = acc_we.size();
        start_pass(8'h33, 9'd0, 32'h5);
        chk("t4_done", 64'(done), 64'(1));
        chk("t4_busy", 64'(busy), 64'(1));
        chk("t4_pass", 64'(pass), 64'(1));
        chk("t4_errc_clr", 64'(err_cnt), 64'(0));
        tick();
        chk("t4_done_off", 64'(done), 64'(0));
        chk("t4_busy_off", 64'(busy), 64'(0));
        chk("t4_nacc", 64'(acc_we.size() - m), 64'(0));

        // Abort in the third write cycle
        m = acc_we.size(); d = n_done;
        start_pass(8'h20, 9'd8, 32'h100);
        tick();
        tick();
        chk("t5_in_w3", 64'(addr0_b0), 64'(8'h22));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_ce", 64'(ce0_b0), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_regen", 64'(reg_en), 64'(0));
        chk("t5_done", 64'(done), 64'(0));
        chk("t5_pass", 64'(pass), 64'(0));
        chk("t5_nacc", 64'(acc_we.size() - m), 64'(3));
        repeat (3) tick();
        chk("t5_no_done", 64'(n_done - d), 64'(0));
        start_pass(8'h20, 9'd8, 32'h100);
        wait_done(cyc);
        chk("t5r_cycles", 64'(cyc), 64'(17));
        chk("t5r_pass", 64'(pass), 64'(1));
        chk("t5r_errc", 64'(err_cnt), 64'(0));
        tick();

        // Start while busy is ignored; reset during READ
        m = acc_we.size();
        start_pass(8'h40, 9'd4, 32'h7);
        base_addr = 8'h80;
        length    = 9'd1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_read_addr", 64'(addr0_b0), 64'(8'h40));
        chk("t6_read_we", 64'(we0_b0), 64'(0));
        chk("t6_read_ce", 64'(ce0_b0), 64'(1));
        d = n_done;
        reset_n = 1'b0;
        tick();
        chk_all_zero("t6_rst");
        reset_n = 1'b1;
        chk("t6_nacc", 64'(acc_we.size() - m), 64'(5));
        chk_acc("t6_w1", m + 1, 1'b1, 8'h41, 32'h8);
        tick();
        chk("t6_no_done", 64'(n_done - d), 64'(0));
        start_pass(8'h40, 9'd4, 32'h7);
        wait_done(cyc);
        chk("t6r_cycles", 64'(cyc), 64'(9));
        chk("t6r_pass", 64'(pass), 64'(1));
        chk("t6r_errc", 64'(err_cnt), 64'(0));
        tick();

        // Full address space from 0x80
        m = acc_we.size();
        start_pass(8'h80, 9'd256, 32'h1000);
        wait_done(cyc);
        chk("t7_cycles", 64'(cyc), 64'(513));
        chk("t7_pass", 64'(pass), 64'(1));
        chk("t7_errc", 64'(err_cnt), 64'(0));
        chk("t7_nacc", 64'(acc_we.size() - m), 64'(512));
        chk_acc("t7_w0",   m,       1'b1, 8'h80, 32'h1000);
        chk_acc("t7_w127", m + 127, 1'b1, 8'hFF, 32'h107F);
        chk_acc("t7_w128", m + 128, 1'b1, 8'h00, 32'h1080);
        chk_acc("t7_r0",   m + 256, 1'b0, 8'h80, 32'h0);
        chk_acc("t7_r255", m + 511, 1'b0, 8'h7F, 32'h0);
        seen = '0;
        dup  = 0;
        for (int i = 0; i < 256; i++) begin
            a = acc_addr[m + i];
            if (seen[a]) dup++;
            seen[a] = 1'b1;
        end
        chk("t7_wr_unique", 64'(dup), 64'(0));
        chk("t7_wr_cover", 64'($countones(seen)), 64'(256));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
